// File: rtl/pong_pkg.sv
// Shared types and widths for the pong game datapath: match states,
// winner encodings and the speed/score/pause widths.
package pong_pkg;

  localparam int SPEED_W = 4;
  localparam int SCORE_W = 4;
  localparam int PAUSE_W = 17;

  localparam logic [SPEED_W-1:0] SPEED_MAX = '1;

  typedef enum logic [1:0] {
    OVER  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2
  } match_state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // A difficulty of 0 would serve a frozen ball, so it is promoted to 1.
  function automatic logic [SPEED_W-1:0] serve_speed(input logic [SPEED_W-1:0] diff);
    return (diff == '0) ? SPEED_W'(1) : diff;
  endfunction

endpackage

// File: rtl/pause_timer.sv
// Pause down-counter for match_ctrl: loadable, with a start shortcut that
// jumps straight to the final count. expire flags the last pause cycle.
module pause_timer
  import pong_pkg::*;
#(
  parameter int RESET_VAL = 131071
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [PAUSE_W-1:0] load_val,
  input  logic               run,
  input  logic               start,
  output logic               expire
);

  logic [PAUSE_W-1:0] count_q, count_d;

  assign expire = (count_q == PAUSE_W'(1));

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (run) begin
      // Expiry wins over start so a late press cannot stall the serve.
      if (expire)                count_d = '0;
      else if (start)            count_d = PAUSE_W'(1);
      else if (count_q != '0)    count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= PAUSE_W'(RESET_VAL);
    else        count_q <= count_d;
  end

endmodule

// File: rtl/match_ctrl.sv
// Match sequencer: pauses, serve, scoring, game over and restart.
// Optional speed ramp on paddle hits is built when MATCH_CTRL_SPEED_RAMP_EN is defined.
module match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 9,
  parameter int POINT_PAUSE = 8000,
  parameter int GAME_PAUSE  = 131071,
  parameter int RAMP_HITS   = 4
) (
  input  logic               game_clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SPEED_W-1:0] difficulty,
  input  logic               out_left,
  input  logic               out_right,
  input  logic               paddle_hit,
  output logic [SPEED_W-1:0] speed,
  output logic               ball_reset,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [1:0]         winner,
  output logic [1:0]         state
);

  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

  match_state_e       state_q, state_d;
  logic [SCORE_W-1:0] score_p1_q, score_p1_d, score_p2_q, score_p2_d;
  logic [SCORE_W-1:0] p1_inc, p2_inc;
  logic [1:0]         winner_q, winner_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               ball_reset_q, ball_reset_d;
  logic               tmr_load, tmr_run, tmr_expire;
  logic [PAUSE_W-1:0] tmr_load_val;

`ifdef MATCH_CTRL_SPEED_RAMP_EN
  localparam int HIT_W = $clog2(RAMP_HITS) + 1;
  logic [HIT_W-1:0] hit_q, hit_d;
`else
  logic paddle_hit_unused;
  assign paddle_hit_unused = paddle_hit;
`endif

  assign p1_inc = score_p1_q + 1'b1;
  assign p2_inc = score_p2_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    score_p1_d   = score_p1_q;
    score_p2_d   = score_p2_q;
    winner_d     = winner_q;
    speed_d      = speed_q;
    ball_reset_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = PAUSE_W'(POINT_PAUSE);
    tmr_run      = (state_q != PLAY);
`ifdef MATCH_CTRL_SPEED_RAMP_EN
    hit_d        = hit_q;
`endif
    case (state_q)
      OVER, SERVE: begin
        speed_d = '0;
        if (tmr_expire) begin
          state_d      = PLAY;
          ball_reset_d = 1'b1;
          speed_d      = serve_speed(difficulty);
`ifdef MATCH_CTRL_SPEED_RAMP_EN
          hit_d        = '0;
`endif
          if (state_q == OVER) begin
            score_p1_d = '0;
            score_p2_d = '0;
            winner_d   = WIN_NONE;
          end
        end
      end
      PLAY: begin
        // out_left takes priority; a hit in a scoring cycle is dropped.
        if (out_left || out_right) begin
          speed_d  = '0;
          tmr_load = 1'b1;
          if (out_left) score_p1_d = p1_inc;
          else          score_p2_d = p2_inc;
          if ((out_left && p1_inc == WIN_S) || (!out_left && p2_inc == WIN_S)) begin
            state_d      = OVER;
            tmr_load_val = PAUSE_W'(GAME_PAUSE);
            winner_d     = out_left ? WIN_P1 : WIN_P2;
          end else begin
            state_d = SERVE;
          end
        end
`ifdef MATCH_CTRL_SPEED_RAMP_EN
        else if (paddle_hit) begin
          if (hit_q == HIT_W'(RAMP_HITS - 1)) begin
            hit_d = '0;
            if (speed_q != SPEED_MAX) speed_d = speed_q + 1'b1;
          end else begin
            hit_d = hit_q + 1'b1;
          end
        end
`endif
      end
      default: begin
        state_d      = OVER;
        tmr_load     = 1'b1;
        tmr_load_val = PAUSE_W'(GAME_PAUSE);
      end
    endcase
  end

  always_ff @(posedge game_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= OVER;
      score_p1_q   <= '0;
      score_p2_q   <= '0;
      winner_q     <= WIN_NONE;
      speed_q      <= '0;
      ball_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      score_p1_q   <= score_p1_d;
      score_p2_q   <= score_p2_d;
      winner_q     <= winner_d;
      speed_q      <= speed_d;
      ball_reset_q <= ball_reset_d;
    end
  end

`ifdef MATCH_CTRL_SPEED_RAMP_EN
  always_ff @(posedge game_clk or negedge reset) begin
    if (!reset) hit_q <= '0;
    else        hit_q <= hit_d;
  end
`endif

  pause_timer #(
    .RESET_VAL (GAME_PAUSE)
  ) u_pause_timer (
    .clk      (game_clk),
    .rst_n    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .run      (tmr_run),
    .start    (start),
    .expire   (tmr_expire)
  );

  assign speed      = speed_q;
  assign ball_reset = ball_reset_q;
  assign score_p1   = score_p1_q;
  assign score_p2   = score_p2_q;
  assign winner     = winner_q;
  assign state      = state_q;

endmodule
